frame_scan_reader: RTL
======================

FRAME_SCAN_READER -- requirements
Module: frame_scan_reader

Interface
REQ-001 Parameter WIDTH, default 640, active pixels per line.
REQ-002 Parameter HEIGHT, default 480, active lines per frame.
REQ-003 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porches and sync width in clk cycles.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porches and sync width in lines.
REQ-005 Parameter RAM_LAT, default 2, frame-buffer read latency in cycles (1..4).
REQ-006 Parameter PIX_W, default 8, pixel data width.
REQ-007 clk  input  1  pixel clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 en  input  1  scan enable; level-sensitive.
REQ-010 ram_rd_addr  output  19  frame-buffer read address.
REQ-011 ram_rd_en  output  1  read strobe; one pixel read per asserted cycle.
REQ-012 ram_rd_data  input  PIX_W  read data, valid RAM_LAT cycles after its ram_rd_en.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 de  output  1  display-enable; high while pixel is active.
REQ-016 pixel  output  PIX_W  pixel value; 0 whenever de is low.
REQ-017 frame_start  output  1  one-cycle pulse on the first active pixel of each frame, aligned with de.

Function
REQ-018 Counters h_cnt 0..H_TOT-1 (H_TOT = WIDTH+H_FP+H_SYNC+H_BP, 800 by default) and v_cnt 0..V_TOT-1 (525); h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 when h_cnt wraps on line V_TOT-1.
REQ-019 Active region: h_cnt < WIDTH and v_cnt < HEIGHT.
REQ-020 Sync windows (undelayed): hsync low for WIDTH+H_FP <= h_cnt < WIDTH+H_FP+H_SYNC; vsync low for HEIGHT+V_FP <= v_cnt < HEIGHT+V_FP+V_SYNC.
REQ-021 ram_rd_en is high exactly in the active region while in state RUN.
REQ-022 Address mapping: ram_rd_addr = v_cnt*WIDTH + h_cnt (row-major, 0-based); it is generated by an incrementing pointer (+1 per read, cleared at h_cnt=0,v_cnt=0) with no multiplier, 19-bit, never exceeding WIDTH*HEIGHT-1.
REQ-023 ram_rd_addr holds its last value when ram_rd_en is low.
REQ-024 hsync, vsync, de and frame_start are delayed RAM_LAT cycles through a shift pipeline so they align with ram_rd_data; pixel = ram_rd_data when delayed de = 1, else 0 (registered together with de).
REQ-025 FSM states: IDLE, RUN, DRAIN.
REQ-026 IDLE: counters held at 0, ram_rd_en=0, syncs high, de=0; en=1 -> RUN next cycle, first RUN cycle has h_cnt=0, v_cnt=0.
REQ-027 RUN: counters advance every cycle; en=0 is ignored until end of frame (h_cnt=H_TOT-1, v_cnt=V_TOT-1), then -> DRAIN if en=0, stay RUN if en=1.
REQ-028 DRAIN: lasts RAM_LAT cycles flushing the alignment pipeline (no new reads), then -> IDLE; en=1 during DRAIN is honoured only after reaching IDLE.
REQ-029 Frames are never truncated: en toggling mid-frame produces no partial frame or sync glitch.
REQ-030 Total latency from ram_rd_en to matching de/pixel output: RAM_LAT+1 cycles.

Reset
REQ-031 rst_n=0 at any clock edge, including mid-frame: state IDLE, counters and address 0, pipeline cleared, ram_rd_en=0, de=0, pixel=0, frame_start=0, hsync=1, vsync=1 on the following cycle.
REQ-032 After reset release, the block stays IDLE until en=1 is sampled.

Verification
REQ-033 Reset, en=1 for 2 frames -> ram_rd_en high 640 cycles/line for 480 lines; first addr 0, last addr 307199; 800*525=420000 cycles per frame.
REQ-034 Sync timing check -> hsync low 96 cycles starting 656 cycles after line start, vsync low exactly 2 lines starting at line 490, both shifted by RAM_LAT.
REQ-035 RAM model returning data=addr[7:0] with RAM_LAT=2 -> pixel at de cycle k of line 0 equals k[7:0]; frame_start pulses once per frame on first de.
REQ-036 en deasserted at line 100 -> frame completes through line 524, then DRAIN 2 cycles, IDLE; no further ram_rd_en.
REQ-037 rst_n pulsed low at h_cnt=300, v_cnt=200 -> next cycle all outputs at reset values; restart with en=1 begins at addr 0.
REQ-038 RAM_LAT=4 sweep -> de/pixel alignment holds, pixel=0 whenever de=0.

Source files
------------

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: raster timing generator that streams a frame buffer out as aligned video
module frame_scan_reader #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int RAM_LAT = 2,
  parameter int PIX_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [18:0]      ram_rd_addr,
  output logic             ram_rd_en,
  input  logic [PIX_W-1:0] ram_rd_data,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] pixel,
  output logic             frame_start
);
  localparam int H_TOT = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);
  localparam int DW = $clog2(RAM_LAT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [DW-1:0] d_cnt;
  logic run, h_end, v_end, act;
  logic [3:0] raw;
  logic [3:0] pipe [RAM_LAT+1];
  assign run = state == RUN;
  assign h_end = h_cnt == HW'(H_TOT - 1);
  assign v_end = v_cnt == VW'(V_TOT - 1);
  assign act = run && h_cnt < HW'(WIDTH) && v_cnt < VW'(HEIGHT);
  assign raw = {act && h_cnt == '0 && v_cnt == '0, act,
                !(run && v_cnt >= VW'(HEIGHT + V_FP) && v_cnt < VW'(HEIGHT + V_FP + V_SYNC)),
                !(run && h_cnt >= HW'(WIDTH + H_FP) && h_cnt < HW'(WIDTH + H_FP + H_SYNC))};
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  // next state: a started frame always runs to completion before en is re-examined
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (en ? RUN : IDLE) :
                run ? ((h_end && v_end && !en) ? DRAIN : RUN) :
                (d_cnt == DW'(RAM_LAT - 1) ? IDLE : DRAIN);
  end
  // raster counters advance only while scanning and rest at 0 otherwise
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + HW'(1);
      v_cnt <= h_end ? (v_end ? '0 : v_cnt + VW'(1)) : v_cnt;
    end
  end
  // drain timer counts the cycles spent flushing the pipeline
  always_ff @(posedge clk) d_cnt <= (!rst_n || state != DRAIN) ? '0 : d_cnt + DW'(1);
  // read strobe and address pointer; pointer restarts on the first pixel and holds between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_rd_en <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_rd_en <= act;
      if (act) ram_rd_addr <= raw[3] ? '0 : ram_rd_addr + 19'd1;
    end
  end
  // control pipeline: stage 0 matches the registered strobe, RAM_LAT more match the RAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= RAM_LAT; i++) pipe[i] <= 4'b0011;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i <= RAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  // output register: pixel captured alongside its display-enable, blanked otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {frame_start, de, vsync, hsync} <= 4'b0011;
      pixel <= '0;
    end else begin
      {frame_start, de, vsync, hsync} <= pipe[RAM_LAT];
      pixel <= pipe[RAM_LAT][2] ? ram_rd_data : '0;
    end
  end
endmodule
